n_clic_pend_sched: RTL and testbench
====================================

Name: n_clic_pend_sched

Overview:
- Hardware pend/unpend scheduler for the n_clic interrupt controller.
- Collects per-vector pend pulses from peripherals, plus "interrupt taken" notifications from the n_clic dispatch logic.
- Serialises them onto the single shared ext_write_enable / ext_data port of the entry CSRs. That port is currently tied off.
- Sits beside n_clic; output drives the pended bit of csr_entry[k].

Parameters:
- VecSize, 8, number of interrupt vectors; must match n_clic.
- VecWidth, $clog2(VecSize), derived index width.
- ClrFifoDepth, 2, depth of the pending-clear FIFO; power of two, at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hw_pend  in  VecSize  per-vector pend request; level sampled each cycle, one-cycle pulse expected
- take_valid  in  1  n_clic dispatched an interrupt this cycle
- take_vec  in  VecWidth  index of the dispatched vector
- csr_block  in  1  core CSR instruction writes an entry CSR this cycle; external write must yield
- ext_write_enable  out  1  write strobe to entry CSR pended bit
- ext_write_idx  out  VecWidth  target vector of the write
- ext_pended_data  out  1  value written: 1 = set pended, 0 = clear pended
- overflow  out  VecSize  sticky per-vector lost-pend flags
- overflow_clr  in  1  clears all overflow flags
- busy  out  1  any set or clear still queued

Behaviour:
- State:
  - req_q[VecSize]: set latches.
  - rr_ptr (VecWidth bits): round-robin pointer.
  - Clear FIFO: ClrFifoDepth entries of VecWidth bits, with rd_ptr, wr_ptr and count.
  - ovf_q[VecSize].
- Reset: all state 0. ext_write_enable=0, ext_write_idx=0, ext_pended_data=0, overflow=0, busy=0. Reset in any cycle discards all queued work and suppresses the write that cycle.
- Outputs are combinational from registered state. A pulse at cycle N is written no earlier than cycle N+1.
- Grant, evaluated each cycle:
  - csr_block=1: ext_write_enable=0. No state consumed; pending work retried next cycle.
  - Otherwise, clear FIFO non-empty: write clear of FIFO head (ext_pended_data=0); pop. Clears have strict priority over sets.
  - Otherwise, any req_q set: select the first set bit at or after rr_ptr, wrapping mod VecSize. Write set (ext_pended_data=1); clear that req_q bit; rr_ptr <= idx+1 mod VecSize (wraps VecSize-1 -> 0).
  - Otherwise idle: ext_write_enable=0, ext_write_idx=0, ext_pended_data=0.
- Set latching, per vector k:
  - hw_pend[k] sets req_q[k].
  - If req_q[k] is granted in the same cycle, the new pulse re-latches it. The result is one further write; no overflow.
  - If req_q[k] is already 1 and not granted this cycle, the pulse is merged and ovf_q[k] <= 1.
- Overflow flags:
  - overflow_clr clears all ovf_q.
  - A new overflow event in the same cycle as overflow_clr wins: that flag stays 1.
- Take handling (only with N_CLIC_AUTO_CLEAR_EN; see below):
  - take_valid pushes take_vec into the clear FIFO.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - Push while full (and no pop that cycle): push dropped; ovf_q[take_vec] <= 1.
- Ordering: a clear and a set for the same vector queued together are written clear first, then set. A fresh pend after a take therefore re-pends.
- busy = (count != 0) | (|req_q).

Optional Feature:
- Macro: N_CLIC_AUTO_CLEAR_EN.
- Defined: behaviour as above; the pended bit of a dispatched vector is cleared in hardware.
- Undefined: take_valid and take_vec are ignored. The clear FIFO and its pointers are not instantiated; count reads 0. Only set writes are issued; software clears pended via CSR.

Decomposition:
- config_pkg gains:
  - ClicVecSize: shared constant with n_clic.
  - clic_pend_op_t: 1-bit enum, PEND_CLR=0, PEND_SET=1.
- Sub-module rr_arbiter(Width), combinational:
  - Inputs: request vector, pointer.
  - Outputs: grant valid, grant index.
  - Reusable for future bus arbitration.

Test Plan:
- Reset, then hw_pend=8'b0000_0100 at cycle 1 -> cycle 2: ext_write_enable=1, idx=2, data=1. Cycle 3 idle, busy=0.
- hw_pend=8'hFF at cycle 1 with rr_ptr=0 -> sets written idx 0,1,…,7 in cycles 2–9. rr_ptr wraps to 0; no overflow.
- hw_pend[3] pulsed cycles 1 and 2, csr_block=1 cycles 2–3 -> overflow[3]=1, a single set to idx 3 in cycle 4. overflow_clr in cycle 5 -> overflow=0 in cycle 6.
- (AUTO_CLEAR) take_valid, take_vec=5 and hw_pend[1] both in cycle 1 -> cycle 2 clear idx 5 (data=0), cycle 3 set idx 1.
- (AUTO_CLEAR) three takes (vec 1, 2, 3) in cycles 1–3 with csr_block=1 throughout -> the third is dropped and overflow[3]=1. After csr_block drops: clears to idx 1 then idx 2 only.
- reset asserted in cycle 2, while req_q=8'h0F -> no write in cycles 2–3; busy=0, overflow=0.

Source files
------------

// File: rtl/n_clic_pend_sched_pkg.sv
// Shared constants and types for the n_clic pend/unpend scheduler.
// Vector count must stay in step with n_clic itself.
package n_clic_pend_sched_pkg;

  localparam int ClicVecSize = 8;

  typedef enum logic {
    PEND_CLR = 1'b0,
    PEND_SET = 1'b1
  } clic_pend_op_t;

  function automatic int wrap_inc(input int idx, input int size);
    return (idx + 1 >= size) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/n_clic_pend_sched_if.sv
// Pend-request, take-notification and entry-CSR write signals of the scheduler.
// slave = scheduler side, master = peripheral/dispatch/CSR side.
interface n_clic_pend_sched_if
  import n_clic_pend_sched_pkg::*;
#(
  parameter int VecSize  = ClicVecSize,
  parameter int VecWidth = $clog2(VecSize)
);

  logic [VecSize-1:0]  hw_pend;
  logic                take_valid;
  logic [VecWidth-1:0] take_vec;
  logic                csr_block;
  logic                overflow_clr;
  logic                ext_write_enable;
  logic [VecWidth-1:0] ext_write_idx;
  logic                ext_pended_data;
  logic [VecSize-1:0]  overflow;
  logic                busy;

  modport master (
    output hw_pend, take_valid, take_vec, csr_block, overflow_clr,
    input  ext_write_enable, ext_write_idx, ext_pended_data, overflow, busy
  );

  modport slave (
    input  hw_pend, take_valid, take_vec, csr_block, overflow_clr,
    output ext_write_enable, ext_write_idx, ext_pended_data, overflow, busy
  );

endinterface

// File: rtl/n_clic_pend_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
// Zero latency; no backpressure, caller decides whether the grant is consumed.
module rr_arbiter #(
  parameter int Width = 8,
  parameter int IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic             gnt_vld_o,
  output logic [IdxW-1:0]  gnt_idx_o
);

  int   j;
  logic found;

  always_comb begin
    found     = 1'b0;
    gnt_idx_o = '0;
    j         = 0;
    for (int i = 0; i < Width; i++) begin
      j = int'(ptr_i) + i;
      if (j >= Width) j = j - Width;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        gnt_idx_o = IdxW'(j);
      end
    end
    gnt_vld_o = found;
  end

endmodule

// File: rtl/n_clic_pend_sched.sv
// Serialises hw pends (round-robin) and, with N_CLIC_AUTO_CLEAR_EN, take-clears (priority) onto the entry-CSR write port.
// Writes appear one cycle after the pulse at the earliest; csr_block stalls the port without consuming work.
module n_clic_pend_sched
  import n_clic_pend_sched_pkg::*;
#(
  parameter int VecSize      = ClicVecSize,
  parameter int VecWidth     = $clog2(VecSize),
  parameter int ClrFifoDepth = 2
) (
  input logic              clk,
  input logic              reset,
  n_clic_pend_sched_if.slave bus
);

  logic [VecSize-1:0]  req_q, req_d, ovf_q, ovf_d, ovf_evt;
  logic [VecWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic                gnt_vld, set_gnt, pop, we, clr_pending, take_drop;
  logic [VecWidth-1:0] gnt_idx, wr_idx, clr_head;
  clic_pend_op_t       op;

  rr_arbiter #(.Width(VecSize), .IdxW(VecWidth)) u_arb (
    .req_i    (req_q),
    .ptr_i    (rr_ptr_q),
    .gnt_vld_o(gnt_vld),
    .gnt_idx_o(gnt_idx)
  );

`ifdef N_CLIC_AUTO_CLEAR_EN
  localparam int PtrW = $clog2(ClrFifoDepth);
  localparam int CntW = $clog2(ClrFifoDepth + 1);

  logic [VecWidth-1:0] clr_mem_q [ClrFifoDepth];
  logic [VecWidth-1:0] clr_mem_d [ClrFifoDepth];
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                push;

  assign clr_pending = (cnt_q != '0);
  assign clr_head    = clr_mem_q[rd_ptr_q];

  // A full FIFO still accepts a take when the head leaves in the same cycle.
  always_comb begin
    push      = bus.take_valid && ((cnt_q != CntW'(ClrFifoDepth)) || pop);
    take_drop = bus.take_valid && !push;
    clr_mem_d = clr_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (push) begin
      clr_mem_d[wr_ptr_q] = bus.take_vec;
      wr_ptr_d            = wr_ptr_q + PtrW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) cnt_d = cnt_q + CntW'(1);
    else if (pop && !push) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_mem_q <= '{default: '0};
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      clr_mem_q <= clr_mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end
`else
  logic unused_take;
  assign unused_take = ^{bus.take_valid, bus.take_vec, pop};
  assign clr_pending = 1'b0;
  assign clr_head    = '0;
  assign take_drop   = 1'b0;
`endif

  always_comb begin
    we      = 1'b0;
    wr_idx  = '0;
    op      = PEND_CLR;
    pop     = 1'b0;
    set_gnt = 1'b0;
    if (!bus.csr_block) begin
      if (clr_pending) begin
        we     = 1'b1;
        wr_idx = clr_head;
        pop    = 1'b1;
      end else if (gnt_vld) begin
        we      = 1'b1;
        wr_idx  = gnt_idx;
        op      = PEND_SET;
        set_gnt = 1'b1;
      end
    end
  end

  // A pulse on a vector granted this cycle re-latches cleanly; otherwise it merges and is flagged lost.
  always_comb begin
    req_d   = req_q;
    ovf_evt = '0;
    if (set_gnt) req_d[gnt_idx] = 1'b0;
    for (int k = 0; k < VecSize; k++) begin
      if (bus.hw_pend[k]) begin
        req_d[k] = 1'b1;
        if (req_q[k] && !(set_gnt && (gnt_idx == VecWidth'(k)))) ovf_evt[k] = 1'b1;
      end
    end
    if (take_drop) ovf_evt[bus.take_vec] = 1'b1;
    ovf_d    = (bus.overflow_clr ? '0 : ovf_q) | ovf_evt;
    rr_ptr_d = set_gnt ? VecWidth'(wrap_inc(int'(gnt_idx), VecSize)) : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q    <= '0;
      ovf_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      req_q    <= req_d;
      ovf_q    <= ovf_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.ext_write_enable = we & ~reset;
  assign bus.ext_write_idx    = reset ? '0 : wr_idx;
  assign bus.ext_pended_data  = ~reset & (op == PEND_SET);
  assign bus.overflow         = reset ? '0 : ovf_q;
  assign bus.busy             = ~reset & (clr_pending | (|req_q));

endmodule

// File: tb/tb_n_clic_pend_sched.sv
// Directed table-driven bench for n_clic_pend_sched; rows are consecutive cycles.
// Auto-clear rows are only present when N_CLIC_AUTO_CLEAR_EN is defined.
module tb_n_clic_pend_sched;

  logic clk = 1'b0;
  logic reset;

  n_clic_pend_sched_if #(.VecSize(8)) bus ();

  n_clic_pend_sched #(.VecSize(8), .ClrFifoDepth(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] hw;
    logic       csr;
    logic       oclr;
    logic       tv;
    logic [2:0] tvec;
    logic       we;
    logic [2:0] idx;
    logic       d;
    logic [7:0] ovf;
    logic       busy;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rst, input logic [7:0] hw, input logic csr,
                              input logic oclr, input logic tv, input logic [2:0] tvec,
                              input logic we, input logic [2:0] idx, input logic d,
                              input logic [7:0] ovf, input logic busy);
    vec_t v;
    v.rst = rst; v.hw = hw; v.csr = csr; v.oclr = oclr; v.tv = tv; v.tvec = tvec;
    v.we = we; v.idx = idx; v.d = d; v.ovf = ovf; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset            = v.rst;
    bus.hw_pend      = v.hw;
    bus.csr_block    = v.csr;
    bus.overflow_clr = v.oclr;
    bus.take_valid   = v.tv;
    bus.take_vec     = v.tvec;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int        nwr;
    logic [7:0] seen;
    logic      drained;

    apply(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));

    // rst, hw, csr, oclr, tv, tvec | we, idx, d, ovf, busy
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h04, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 2, 1, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    // full burst from rr_ptr=0
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 3'(i), 1, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    // merged pend under csr_block, then overflow_clr
    tbl.push_back(mk(0, 8'h08, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h08, 1, 0, 0, 0, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h08, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 3, 1, 8'h08, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 8'h08, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    // re-pend in the grant cycle: second write, no overflow
    tbl.push_back(mk(0, 8'h10, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h10, 0, 0, 0, 0, 1, 4, 1, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 4, 1, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    // rr_ptr=5: vector 5 before vector 0
    tbl.push_back(mk(0, 8'h21, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 5, 1, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    // reset discards queued sets and overflow
    tbl.push_back(mk(0, 8'h0F, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h01, 1, 0, 0, 0, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h01, 1));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
`ifdef N_CLIC_AUTO_CLEAR_EN
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h02, 0, 0, 1, 5, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 5, 0, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    // third take while full and blocked is dropped
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 2, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 3, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h08, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 2, 0, 8'h08, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 8'h08, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    // push into full FIFO alongside a pop is kept
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 4, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 5, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 6, 1, 4, 0, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 5, 0, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 6, 0, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    // clear then set for the same vector
    tbl.push_back(mk(0, 8'h80, 0, 0, 1, 7, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 7, 0, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 7, 1, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
`endif

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk($sformatf("row%0d.we", i),   32'(bus.ext_write_enable), 32'(tbl[i].we));
      chk($sformatf("row%0d.idx", i),  32'(bus.ext_write_idx),    32'(tbl[i].idx));
      chk($sformatf("row%0d.data", i), 32'(bus.ext_pended_data),  32'(tbl[i].d));
      chk($sformatf("row%0d.ovf", i),  32'(bus.overflow),         32'(tbl[i].ovf));
      chk($sformatf("row%0d.busy", i), 32'(bus.busy),             32'(tbl[i].busy));
    end

    // Burst drain with a bounded wait: every vector written exactly once.
    @(negedge clk);
    apply(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    @(negedge clk);
    apply(mk(0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    nwr     = 0;
    seen    = '0;
    drained = 1'b0;
    for (int c = 0; c < 20 && !drained; c++) begin
      @(negedge clk);
      apply(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
      #1;
      if (bus.ext_write_enable) begin
        nwr++;
        seen[bus.ext_write_idx] = 1'b1;
      end
      if (!bus.busy) drained = 1'b1;
    end
    chk("burst_drained", 32'(drained), 32'd1);
    chk("burst_count",   32'(nwr),     32'd8);
    chk("burst_vectors", 32'(seen),    32'hFF);
    chk("burst_no_ovf",  32'(bus.overflow), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
